parity_arbiter: RTL and testbench
=================================

PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 Parameter: ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 holds a word for checking.
REQ-005 req0_data  input  3  requester 0 data bits {a,b,c}.
REQ-006 req0_par  input  1  requester 0 even-parity bit p.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid, req1_data[2:0], req1_par, req1_ready SHALL have the same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  1  requester that owns the result (0 or 1).
REQ-011 rsp_err  output  1  parity error: 1 when a^b^c^p = 1.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 clr_count  input  1  synchronous clear of err_count.
REQ-014 err_count  output  ERR_CNT_W  number of errored words checked.

Function
REQ-015 The block SHALL share one even-parity check path between the two requesters using an FSM with states IDLE, CHECK and RESP.
REQ-016 IDLE: when at least one reqN_valid is high, the FSM SHALL grant exactly one requester, drive its reqN_ready high combinationally in that cycle, latch its data, parity and id, and move to CHECK.
REQ-017 reqN_ready SHALL be low in CHECK and RESP, and low for the non-granted requester.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-019 The last-grant pointer SHALL update only on an accepted request.
REQ-020 CHECK: the FSM SHALL register rsp_err from the latched word, set rsp_id, and move to RESP.
REQ-021 RESP: rsp_valid SHALL be high and rsp_id/rsp_err SHALL stay stable until rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-022 Latency: a word accepted in cycle N SHALL present rsp_valid in cycle N+2.
REQ-023 Minimum spacing between acceptances SHALL be 3 cycles when rsp_ready is tied high.
REQ-024 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-025 err_count SHALL increment on the CHECK->RESP transition when the result is an error.
REQ-026 err_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 If clr_count is high in the same cycle as an increment, clear SHALL win and err_count SHALL become 0.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_id=0, rsp_err=0, err_count=0, and the last-grant pointer=1 so requester 0 wins the first tie.
REQ-029 req0_ready and req1_ready SHALL be 0 while rst_n is low.
REQ-030 Reset asserted mid-transaction SHALL discard the in-flight word without producing a response.

Structure
REQ-031 State encodings (IDLE, CHECK, RESP) and the default counter width SHALL be defined in a shared package parity_pkg.
REQ-032 The parity computation SHALL be one instance of the existing combinational even_parity_checker sub-module, driven from the latched word.
REQ-033 The FSM, arbiter and counter SHALL reside in parity_arbiter.

Verification
REQ-034 Only req0 valid, data=3'b101, par=0, rsp_ready=1 -> req0_ready pulse in cycle N; rsp_valid in N+2 with rsp_id=0, rsp_err=0; err_count stays 0.
REQ-035 Both requesters continuously valid after reset, rsp_ready=1 -> grant order 0,1,0,1; each response carries the matching rsp_id.
REQ-036 req1 data=3'b011, par=1 with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_id=1, rsp_err=1 held stable; no readies issued; err_count=1.
REQ-037 ERR_CNT_W=2, five errored words -> err_count 1,2,3,3,3; clr_count pulsed coincident with a sixth error -> err_count=0.
REQ-038 rst_n pulled low during CHECK -> all outputs return to reset values asynchronously, no response appears after release, and the next tie grants requester 0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and defaults for the parity arbiter slice.
package parity_pkg;

  localparam int unsigned ERR_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StResp
  } state_e;

endpackage

// File: rtl/parity_arbiter_if.sv
// Two requester handshakes plus the response channel of the parity arbiter.
interface parity_arbiter_if;

  logic       req0_valid;
  logic [2:0] req0_data;
  logic       req0_par;
  logic       req0_ready;

  logic       req1_valid;
  logic [2:0] req1_data;
  logic       req1_par;
  logic       req1_ready;

  logic       rsp_valid;
  logic       rsp_id;
  logic       rsp_err;
  logic       rsp_ready;

  modport master (
    output req0_valid, req0_data, req0_par,
    input  req0_ready,
    output req1_valid, req1_data, req1_par,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_par,
    output req0_ready,
    input  req1_valid, req1_data, req1_par,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/even_parity_checker.sv
// Combinational even-parity check: err is high when data and parity bit have odd weight.
module even_parity_checker (
  input  logic [2:0] data,
  input  logic       par,
  output logic       err
);

  assign err = ^{data, par};

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one even-parity check path between two requesters,
// with a saturating count of errored words.
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_arbiter_if.slave      bus,
  input  logic                 clr_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_e               state_q, state_d;
  logic                 last_q;
  logic                 any_valid;
  logic                 gnt_id;
  logic                 ready0, ready1;
  logic                 accept;
  logic [2:0]           data_q;
  logic                 par_q;
  logic                 id_q;
  logic                 rsp_id_q;
  logic                 rsp_err_q;
  logic                 par_err;
  logic [ERR_CNT_W-1:0] cnt_q;

  // With a tie, grant whoever did not win last; otherwise the lone requester.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = bus.req1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_valid) state_d = StCheck;
      StCheck: state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Readies are gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    ready0        = 1'b0;
    ready1        = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rst_n && any_valid) begin
          ready0 = ~gnt_id;
          ready1 = gnt_id;
        end
      end
      StResp:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept         = ready0 | ready1;
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign err_count      = cnt_q;

  even_parity_checker u_checker (
    .data (data_q),
    .par  (par_q),
    .err  (par_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      data_q    <= '0;
      par_q     <= 1'b0;
      id_q      <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        data_q <= gnt_id ? bus.req1_data : bus.req0_data;
        par_q  <= gnt_id ? bus.req1_par : bus.req0_par;
      end
      if (state_q == StCheck) begin
        rsp_id_q  <= id_q;
        rsp_err_q <= par_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_count) begin
      cnt_q <= '0;
    end else if (state_q == StCheck && par_err && cnt_q != '1) begin
      cnt_q <= cnt_q + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter with a 2-bit error counter.
module tb_parity_arbiter;

  localparam int unsigned CntW = 2;

  logic            clk;
  logic            rst_n;
  logic            clr_count;
  logic [CntW-1:0] err_count;
  int              n_total;
  int              n_bad;

  parity_arbiter_if bus ();

  parity_arbiter #(
    .ERR_CNT_W (CntW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_data  = 3'b000;
    bus.req0_par   = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 3'b000;
    bus.req1_par   = 1'b0;
    bus.rsp_ready  = 1'b1;
    clr_count      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_total = 0;
    n_bad   = 0;

    // Reset state, with both requesters pushing during reset.
    rst_n = 1'b0;
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    cyc();
    #3;
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_err_count", err_count, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single clean word from requester 0: 101 with p=0 has even weight.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 3'b101;
    bus.req0_par   = 1'b0;
    #3;
    check("t1_ready0", bus.req0_ready, 1);
    check("t1_ready1", bus.req1_ready, 0);
    cyc();
    bus.req0_valid = 1'b0;
    #3;
    check("t1_n1_valid", bus.rsp_valid, 0);
    check("t1_n1_ready0", bus.req0_ready, 0);
    cyc();
    #3;
    check("t1_n2_valid", bus.rsp_valid, 1);
    check("t1_n2_id", bus.rsp_id, 0);
    check("t1_n2_err", bus.rsp_err, 0);
    check("t1_count", err_count, 0);
    cyc();
    #3;
    check("t1_n3_valid", bus.rsp_valid, 0);

    // Continuous tie after reset: expect grants 0,1,0,1 spaced three cycles.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 3'b000;
    bus.req0_par   = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 3'b001;
    bus.req1_par   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = (i % 2) == 1;
      #3;
      check("t2_ready0", bus.req0_ready, !e);
      check("t2_ready1", bus.req1_ready, e);
      cyc();
      cyc();
      #3;
      check("t2_rsp_valid", bus.rsp_valid, 1);
      check("t2_rsp_id", bus.rsp_id, e);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Errored word from requester 1 held under back-pressure: 0^1^1^1 = 1.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 3'b011;
    bus.req1_par   = 1'b1;
    #3;
    check("t3_ready1", bus.req1_ready, 1);
    cyc();
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    cyc();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      check("t3_hold_valid", bus.rsp_valid, 1);
      check("t3_hold_id", bus.rsp_id, 1);
      check("t3_hold_err", bus.rsp_err, 1);
      check("t3_hold_ready0", bus.req0_ready, 0);
      check("t3_hold_ready1", bus.req1_ready, 0);
      check("t3_hold_count", err_count, 1);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    cyc();
    #3;
    check("t3_released", bus.rsp_valid, 0);

    // Saturation of the 2-bit counter, then clear coinciding with an increment.
    clr_count = 1'b1;
    cyc();
    clr_count = 1'b0;
    #3;
    check("t4_cleared", err_count, 0);
    for (int k = 0; k < 5; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 3'b001;
      bus.req0_par   = 1'b0;
      cyc();
      bus.req0_valid = 1'b0;
      cyc();
      #3;
      check("t4_err", bus.rsp_err, 1);
      check("t4_count", err_count, (k < 3) ? k + 1 : 3);
      cyc();
    end
    bus.req0_valid = 1'b1;
    cyc();
    bus.req0_valid = 1'b0;
    clr_count = 1'b1;
    cyc();
    clr_count = 1'b0;
    #3;
    check("t4_clr_wins", err_count, 0);
    cyc();

    // Reset during CHECK of a requester-0 word.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 3'b011;
    bus.req1_par   = 1'b1;
    cyc();
    bus.req1_valid = 1'b0;
    cyc();
    #3;
    check("t5_pre_count", err_count, 1);
    check("t5_pre_id", bus.rsp_id, 1);
    cyc();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 3'b111;
    bus.req0_par   = 1'b0;
    cyc();
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", bus.rsp_valid, 0);
    check("t5_async_id", bus.rsp_id, 0);
    check("t5_async_err", bus.rsp_err, 0);
    check("t5_async_count", err_count, 0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    cyc();
    #3;
    check("t5_rst_ready0", bus.req0_ready, 0);
    check("t5_rst_ready1", bus.req1_ready, 0);
    cyc();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #3;
      check("t5_no_rsp", bus.rsp_valid, 0);
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("t5_tie_ready0", bus.req0_ready, 1);
    check("t5_tie_ready1", bus.req1_ready, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
